// File: rtl/drum_pkg.sv
// Shared types and default sizing for the DRUM approximate multiplier pipeline.
package drum_pkg;

   localparam int unsigned DRUM_N_DEF = 16;
   localparam int unsigned LOD_W      = $clog2(DRUM_N_DEF);
   localparam int unsigned SH_W       = LOD_W + 1;

   typedef enum logic {
      MODE_MULT   = 1'b0,
      MODE_SQUARE = 1'b1
   } mode_e;

   // Per-stage control payload carried alongside the datapath registers
   typedef struct packed {
      logic valid;
      logic sign;
   } stage_ctl_t;

endpackage

// File: rtl/drum_sel.sv
// Combinational DRUM operand reduction: |x|, leading-one detect and K-bit window select.
module drum_sel #(
   parameter int unsigned N  = 16,
   parameter int unsigned K  = 5,
   parameter int unsigned LW = $clog2(N)
) (
   input  logic [N-1:0]  x,
   output logic [K-1:0]  sel,
   output logic [LW-1:0] sh,
   output logic          is_zero,
   output logic          sign
);

   logic [N-1:0]  mag;
   logic [LW-1:0] lead;

   always_comb begin
      sign    = x[N-1];
      mag     = sign ? N'(-x) : x;
      is_zero = (mag == '0);
      lead    = '0;
      sel     = '0;
      sh      = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (mag[i]) lead = LW'(i);
      end
      // Small magnitudes are exact; larger ones keep K-1 bits below the leading one plus a forced 1
      if (32'(lead) < K) begin
         sel = mag[K-1:0];
      end else begin
         sh  = LW'(32'(lead) - K + 32'd1);
         sel = K'(mag >> sh) | K'(1);
      end
   end

endmodule

// File: rtl/drum_mult_pipe.sv
// 3-stage pipelined DRUM approximate signed multiplier/squarer with valid/ready flow control.
// Define DRUM_SAT_EN to clamp out-of-range results instead of two's-complement wrapping.
module drum_mult_pipe
   import drum_pkg::*;
#(
   parameter int unsigned N          = 16,
   parameter int unsigned K          = 5,
   parameter int unsigned POST_SHIFT = 8,
   parameter int unsigned OUT_W      = 2 * N
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_mode,
   input  logic [N-1:0]            in_a,
   input  logic [N-1:0]            in_b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data
);

   localparam int unsigned LW = (N == DRUM_N_DEF) ? LOD_W : $clog2(N);
   localparam int unsigned SW = (N == DRUM_N_DEF) ? SH_W : $clog2(N) + 1;
   localparam int unsigned PW = 2 * K;
   localparam int unsigned EW = (OUT_W + 1 > 2 * N + 2) ? OUT_W + 1 : 2 * N + 2;

   logic stall;

   logic [K-1:0]  sel_a, sel_b;
   logic [LW-1:0] sh_a, sh_b;
   logic          zero_a, zero_b, sign_a, sign_b;

   stage_ctl_t    s1_ctl_n;
   logic [K-1:0]  s1_sel_b_n;
   logic [LW-1:0] s1_sh_b_n;

   stage_ctl_t    s1_ctl, s2_ctl;
   logic [K-1:0]  s1_sel_a, s1_sel_b;
   logic [LW-1:0] s1_sh_a, s1_sh_b;
   logic [PW-1:0] s2_prod;
   logic [SW-1:0] s2_sh;

   logic [EW-1:0]         s3_mag;
   logic signed [EW-1:0]  s3_res;
   logic [OUT_W-1:0]      s3_out;

   // The whole pipe, bubbles included, freezes while the output is blocked
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   drum_sel #(.N(N), .K(K), .LW(LW)) u_sel_a (
      .x(in_a), .sel(sel_a), .sh(sh_a), .is_zero(zero_a), .sign(sign_a)
   );

   drum_sel #(.N(N), .K(K), .LW(LW)) u_sel_b (
      .x(in_b), .sel(sel_b), .sh(sh_b), .is_zero(zero_b), .sign(sign_b)
   );

   // S1 operand routing and result sign; a zero operand never yields a negative result
   always_comb begin
      s1_ctl_n.valid = in_valid;
      s1_ctl_n.sign  = 1'b0;
      s1_sel_b_n     = sel_b;
      s1_sh_b_n      = sh_b;
      if (mode_e'(in_mode) == MODE_SQUARE) begin
         s1_sel_b_n = sel_a;
         s1_sh_b_n  = sh_a;
      end else begin
         s1_ctl_n.sign = (sign_a ^ sign_b) & ~(zero_a | zero_b);
      end
   end

   // S3 shift, sign and width reduction
   always_comb begin
      s3_mag = (EW'(s2_prod) << s2_sh) >> POST_SHIFT;
      s3_res = s2_ctl.sign ? -$signed(s3_mag) : $signed(s3_mag);
`ifdef DRUM_SAT_EN
      if (s3_res > $signed(EW'({1'b0, {(OUT_W-1){1'b1}}}))) begin
         s3_out = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (s3_res < $signed(~EW'({1'b0, {(OUT_W-1){1'b1}}}))) begin
         s3_out = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         s3_out = OUT_W'(s3_res);
      end
`else
      s3_out = OUT_W'(s3_res);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_ctl    <= '0;
         s1_sel_a  <= '0;
         s1_sel_b  <= '0;
         s1_sh_a   <= '0;
         s1_sh_b   <= '0;
         s2_ctl    <= '0;
         s2_prod   <= '0;
         s2_sh     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (!stall) begin
         s1_ctl    <= s1_ctl_n;
         s1_sel_a  <= sel_a;
         s1_sel_b  <= s1_sel_b_n;
         s1_sh_a   <= sh_a;
         s1_sh_b   <= s1_sh_b_n;
         s2_ctl    <= s1_ctl;
         s2_prod   <= PW'(s1_sel_a) * PW'(s1_sel_b);
         s2_sh     <= SW'(s1_sh_a) + SW'(s1_sh_b);
         out_valid <= s2_ctl.valid;
         out_data  <= s3_out;
      end
   end

endmodule

// File: tb/tb_drum_mult_pipe.sv
// Directed bench for drum_mult_pipe: a 32-bit and a 16-bit output instance share one stimulus stream.
module tb_drum_mult_pipe;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_mode;
   logic [15:0]        in_a, in_b;
   logic               out_ready;
   logic               in_ready, in_ready16;
   logic               out_valid, out_valid16;
   logic signed [31:0] out_data;
   logic signed [15:0] out_data16;

   int n_cmp = 0;
   int n_bad = 0;
   int n_out = 0;
   longint expq[$];

   typedef struct {
      string              name;
      logic               mode;
      logic signed [15:0] a;
      logic signed [15:0] b;
      longint             exp;
   } vec_t;

   vec_t vecs[14];

   always #5 clk = ~clk;

   drum_mult_pipe u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
   );

   drum_mult_pipe #(.OUT_W(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
      .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .out_valid(out_valid16),
      .out_ready(out_ready), .out_data(out_data16)
   );

   // Expected 16-bit result derived from the full-precision expected value
   function automatic longint red16(input longint v);
      logic [63:0] t;
      logic [15:0] lo;
      t  = 64'(v);
      lo = t[15:0];
`ifdef DRUM_SAT_EN
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
`else
      return longint'($signed(lo));
`endif
   endfunction

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Output scoreboard: every transfer must match the oldest accepted operand pair
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               chk("out_data", $signed(out_data), expq[0]);
               chk("out_data16", $signed(out_data16), red16(expq[0]));
               chk("out_valid16", out_valid16, 1);
               void'(expq.pop_front());
               n_out <= n_out + 1;
            end
         end else if (out_valid && !out_ready && expq.size() != 0) begin
            chk("stall_hold_data", $signed(out_data), expq[0]);
         end
      end
   end

   task automatic stream(input int first, input int cnt, input bit stall_win);
      int idx = first;
      int c   = 0;
      while (idx < first + cnt && c < 200) begin
         in_valid  = 1'b1;
         in_mode   = vecs[idx].mode;
         in_a      = vecs[idx].a;
         in_b      = vecs[idx].b;
         out_ready = !(stall_win && c >= 4 && c <= 7);
         @(negedge clk);
         if (stall_win && c >= 4 && c <= 7) begin
            chk("in_ready_stalled", in_ready, 0);
            chk("in_ready16_stalled", in_ready16, 0);
         end else begin
            chk("in_ready_free", in_ready, 1);
         end
         if (in_ready) begin
            expq.push_back(vecs[idx].exp);
            idx++;
         end
         @(posedge clk);
         #1;
         c++;
      end
      if (idx != first + cnt) chk("stream_timeout", idx, first + cnt);
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic drain();
      int t = 0;
      while (expq.size() != 0 && t < 50) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("drain_empty", expq.size(), 0);
   endtask

   initial begin
      int base;
      vecs[0]  = '{"sq_256",       1'b1,  16'sd256,    16'sd0,     289};
      vecs[1]  = '{"sq_m256",      1'b1, -16'sd256,    16'sd0,     289};
      vecs[2]  = '{"mul_16_m16",   1'b0,  16'sd16,    -16'sd16,    -1};
      vecs[3]  = '{"mul_3_3",      1'b0,  16'sd3,      16'sd3,     0};
      vecs[4]  = '{"sq_min",       1'b1, -16'sd32768,  16'sd0,     4734976};
      vecs[5]  = '{"mul_0_m5",     1'b0,  16'sd0,     -16'sd5,     0};
      vecs[6]  = '{"mul_100_200",  1'b0,  16'sd100,    16'sd200,   78};
      vecs[7]  = '{"sq_256_bjunk", 1'b1,  16'sd256,   -16'sd1,     289};
      vecs[8]  = '{"mul_m100_200", 1'b0, -16'sd100,    16'sd200,   -78};
      vecs[9]  = '{"sq_31",        1'b1,  16'sd31,     16'sd5,     3};
      vecs[10] = '{"mul_31_m31",   1'b0,  16'sd31,    -16'sd31,    -3};
      vecs[11] = '{"mul_max_max",  1'b0,  16'sd32767,  16'sd32767, 3936256};
      vecs[12] = '{"mul_min_max",  1'b0, -16'sd32768,  16'sd32767, -4317184};
      vecs[13] = '{"mul_m5_0",     1'b0, -16'sd5,      16'sd0,     0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", $signed(out_data), 0);
      chk("reset_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single transaction: result appears exactly three edges after acceptance
      in_valid = 1'b1;
      in_mode  = 1'b1;
      in_a     = 16'sd256;
      in_b     = 16'sd0;
      @(negedge clk);
      chk("lat_in_ready", in_ready, 1);
      expq.push_back(289);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("lat_cycle1_valid", out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_cycle2_valid", out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_cycle3_valid", out_valid, 1);
      chk("lat_cycle3_data", $signed(out_data), 289);
      drain();

      // Full table back-to-back at full throughput
      stream(0, 14, 1'b0);
      drain();

      // Ten back-to-back with the output blocked for cycles 4..7
      base = n_out;
      stream(0, 10, 1'b1);
      drain();
      chk("stall_out_count", n_out - base, 10);

      // Reset with three operands in flight
      stream(0, 3, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", $signed(out_data), 0);
      chk("midrst_in_ready", in_ready, 1);
      expq.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_idle", out_valid, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
